// File: rtl/mem_rd_arbiter_if.sv
// Bundle of the two requester read ports, the downstream memory read port and status,
// shared between mem_rd_arbiter (slave modport) and its environment (master modport).
interface mem_rd_arbiter_if #(
    parameter int DATA_LEN = 32,
    parameter int ID_W     = 1
);
    logic                m0_arvalid;
    logic                m0_arready;
    logic [DATA_LEN-1:0] m0_raddr;
    logic                m0_rvalid;
    logic                m0_rready;
    logic [2:0]          m0_rresp;
    logic [DATA_LEN-1:0] m0_rdata;

    logic                m1_arvalid;
    logic                m1_arready;
    logic [DATA_LEN-1:0] m1_raddr;
    logic                m1_rvalid;
    logic                m1_rready;
    logic [2:0]          m1_rresp;
    logic [DATA_LEN-1:0] m1_rdata;

    logic                mem_arvalid;
    logic                mem_arready;
    logic [DATA_LEN-1:0] mem_raddr;
    logic                mem_rvalid;
    logic                mem_rready;
    logic [2:0]          mem_rresp;
    logic [DATA_LEN-1:0] mem_rdata;

    logic                busy;
    logic [ID_W-1:0]     owner;

    modport slave (
        input  m0_arvalid, m0_raddr, m0_rready,
        input  m1_arvalid, m1_raddr, m1_rready,
        input  mem_arready, mem_rvalid, mem_rresp, mem_rdata,
        output m0_arready, m0_rvalid, m0_rresp, m0_rdata,
        output m1_arready, m1_rvalid, m1_rresp, m1_rdata,
        output mem_arvalid, mem_raddr, mem_rready,
        output busy, owner
    );

    modport master (
        output m0_arvalid, m0_raddr, m0_rready,
        output m1_arvalid, m1_raddr, m1_rready,
        output mem_arready, mem_rvalid, mem_rresp, mem_rdata,
        input  m0_arready, m0_rvalid, m0_rresp, m0_rdata,
        input  m1_arready, m1_rvalid, m1_rresp, m1_rdata,
        input  mem_arvalid, mem_raddr, mem_rready,
        input  busy, owner
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-requester single-outstanding read arbiter (icache = m0, LSU = m1) onto one memory read port.
// Define MEM_RD_ARB_ROUND_ROBIN_EN for round-robin ties; default build gives m1 fixed priority.
module mem_rd_arbiter #(
    parameter int DATA_LEN = 32,
    parameter int ID_W     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_rd_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t              r_state;
    logic                r_mem_arvalid;
    logic [DATA_LEN-1:0] r_mem_raddr;
    logic [ID_W-1:0]     r_owner;
    logic                r_busy;
    logic                r_last_grant;

    logic                w_grant;
    logic                w_idle;
    logic                w_data;
    logic                w_up_hs;
    logic [DATA_LEN-1:0] w_up_addr;
    logic                w_mem_rready;

    // Arbitration: pick which requester may handshake in IDLE.
    always_comb begin
        w_grant = 1'b0;
`ifdef MEM_RD_ARB_ROUND_ROBIN_EN
        if (bus.m0_arvalid && bus.m1_arvalid) begin
            w_grant = ~r_last_grant;
        end else if (bus.m1_arvalid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
`else
        if (bus.m1_arvalid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
`endif
    end

`ifndef MEM_RD_ARB_ROUND_ROBIN_EN
    // last_grant is tracked in both builds; only round-robin consults it.
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
`endif

    assign w_idle         = (r_state == ST_IDLE);
    assign w_data         = (r_state == ST_DATA);
    assign bus.m0_arready = w_idle & ~w_grant;
    assign bus.m1_arready = w_idle & w_grant;
    assign w_up_hs        = w_idle & (w_grant ? bus.m1_arvalid : bus.m0_arvalid);
    assign w_up_addr      = w_grant ? bus.m1_raddr : bus.m0_raddr;

    // Read-data pass-through to the current owner only while in DATA.
    always_comb begin
        bus.m0_rvalid = 1'b0;
        bus.m0_rdata  = {DATA_LEN{1'b0}};
        bus.m0_rresp  = 3'h0;
        bus.m1_rvalid = 1'b0;
        bus.m1_rdata  = {DATA_LEN{1'b0}};
        bus.m1_rresp  = 3'h0;
        w_mem_rready  = 1'b0;
        if (w_data) begin
            if (r_owner[0]) begin
                bus.m1_rvalid = bus.mem_rvalid;
                bus.m1_rdata  = bus.mem_rdata;
                bus.m1_rresp  = bus.mem_rresp;
                w_mem_rready  = bus.m1_rready;
            end else begin
                bus.m0_rvalid = bus.mem_rvalid;
                bus.m0_rdata  = bus.mem_rdata;
                bus.m0_rresp  = bus.mem_rresp;
                w_mem_rready  = bus.m0_rready;
            end
        end else begin
            w_mem_rready = 1'b0;
        end
    end

    assign bus.mem_arvalid = r_mem_arvalid;
    assign bus.mem_raddr   = r_mem_raddr;
    assign bus.mem_rready  = w_mem_rready;
    assign bus.busy        = r_busy;
    assign bus.owner       = r_owner;

    // Transaction FSM: IDLE -> ADDR (address out) -> DATA (response back) -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mem_arvalid <= 1'b0;
            r_mem_raddr   <= {DATA_LEN{1'b0}};
            r_owner       <= {ID_W{1'b0}};
            r_busy        <= 1'b0;
            r_last_grant  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_up_hs) begin
                        r_mem_raddr   <= w_up_addr;
                        r_owner       <= ID_W'(w_grant);
                        r_mem_arvalid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.mem_arready) begin
                        r_mem_arvalid <= 1'b0;
                        r_state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.mem_rvalid && w_mem_rready) begin
                        r_last_grant <= r_owner[0];
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_mem_arvalid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Randomized bench for mem_rd_arbiter against a transaction-level arbitration model.
module tb_mem_rd_arbiter;

    localparam int DATA_LEN = 32;
    localparam int ID_W     = 1;
`ifdef MEM_RD_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    mem_rd_arbiter_if #(.DATA_LEN(DATA_LEN), .ID_W(ID_W)) bus ();

    mem_rd_arbiter #(.DATA_LEN(DATA_LEN), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          pend_v [2];
    logic [31:0] pend_a [2];
    bit          last_grant;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // One full transaction from the model's pending requests; called just after a negedge in IDLE.
    task automatic run_txn(input int stall_a, input int stall_r, input logic [2:0] resp,
                           input logic [31:0] data, input bit noise);
        int          w;
        logic [31:0] a;
        bus.m0_arvalid = pend_v[0];
        bus.m0_raddr   = pend_a[0];
        bus.m1_arvalid = pend_v[1];
        bus.m1_raddr   = pend_a[1];
        if (pend_v[0] && pend_v[1]) w = RR_EN ? (last_grant ? 0 : 1) : 1;
        else                        w = pend_v[1] ? 1 : 0;
        a = pend_a[w];
        #1;
        check_eq("idle_arready0", 64'(bus.m0_arready), 64'(w == 0));
        check_eq("idle_arready1", 64'(bus.m1_arready), 64'(w == 1));
        check_eq("idle_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_eq("addr_arvalid", 64'(bus.mem_arvalid), 64'd1);
        check_eq("addr_raddr", 64'(bus.mem_raddr), 64'(a));
        check_eq("addr_owner", 64'(bus.owner), 64'(w));
        check_eq("addr_busy", 64'(bus.busy), 64'd1);
        check_eq("addr_no_regrant", 64'({bus.m0_arready, bus.m1_arready}), 64'd0);
        pend_v[w] = 1'b0;
        if (w == 1) bus.m1_arvalid = 1'b0;
        else        bus.m0_arvalid = 1'b0;
        for (int i = 0; i < stall_a; i++) begin
            bus.mem_arready = 1'b0;
            bus.mem_rvalid  = noise;
            bus.mem_rdata   = $urandom;
            #1;
            check_eq("stray_rready", 64'(bus.mem_rready), 64'd0);
            check_eq("stray_rvalid", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
            @(negedge clk);
            check_eq("stall_arvalid", 64'(bus.mem_arvalid), 64'd1);
            check_eq("stall_raddr", 64'(bus.mem_raddr), 64'(a));
        end
        bus.mem_arready = 1'b1;
        bus.mem_rvalid  = 1'b0;
        @(negedge clk);
        bus.mem_arready = 1'b0;
        check_eq("data_arvalid", 64'(bus.mem_arvalid), 64'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        bus.mem_rresp  = resp;
        for (int i = 0; i <= stall_r; i++) begin
            bit rdy;
            rdy = (i == stall_r);
            if (w == 1) begin bus.m1_rready = rdy; bus.m0_rready = 1'($urandom_range(0, 1)); end
            else        begin bus.m0_rready = rdy; bus.m1_rready = 1'($urandom_range(0, 1)); end
            #1;
            check_eq("data_mem_rready", 64'(bus.mem_rready), 64'(rdy));
            check_eq("data_own_rvalid", 64'(w == 1 ? bus.m1_rvalid : bus.m0_rvalid), 64'd1);
            check_eq("data_own_rdata", 64'(w == 1 ? bus.m1_rdata : bus.m0_rdata), 64'(data));
            check_eq("data_own_rresp", 64'(w == 1 ? bus.m1_rresp : bus.m0_rresp), 64'(resp));
            check_eq("data_oth_rvalid", 64'(w == 1 ? bus.m0_rvalid : bus.m1_rvalid), 64'd0);
            check_eq("data_oth_rdata", 64'(w == 1 ? bus.m0_rdata : bus.m1_rdata), 64'd0);
            check_eq("data_oth_rresp", 64'(w == 1 ? bus.m0_rresp : bus.m1_rresp), 64'd0);
            check_eq("data_no_regrant", 64'({bus.m0_arready, bus.m1_arready}), 64'd0);
            @(negedge clk);
            check_eq("data_busy", 64'(bus.busy), 64'(!rdy));
        end
        bus.mem_rvalid = 1'b0;
        bus.m0_rready  = 1'b0;
        bus.m1_rready  = 1'b0;
        last_grant     = w[0];
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.m0_arvalid  = 1'b0; bus.m0_raddr = 32'h0; bus.m0_rready = 1'b0;
        bus.m1_arvalid  = 1'b0; bus.m1_raddr = 32'h0; bus.m1_rready = 1'b0;
        bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0;
        bus.mem_rresp   = 3'h0; bus.mem_rdata  = 32'h0;
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        pend_a[0] = 32'h0; pend_a[1] = 32'h0;
        last_grant = 1'b1;
        #3;
        check_eq("rst_arvalid", 64'(bus.mem_arvalid), 64'd0);
        check_eq("rst_raddr", 64'(bus.mem_raddr), 64'd0);
        check_eq("rst_owner", 64'(bus.owner), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_arready", 64'({bus.m0_arready, bus.m1_arready}), 64'd2);
        check_eq("rst_rvalid", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        check_eq("rst_rready", 64'(bus.mem_rready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single icache refill beat.
        pend_v[0] = 1'b1; pend_a[0] = 32'h8000_0010;
        run_txn(0, 0, 3'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset while the address is still waiting downstream.
        bus.m1_arvalid = 1'b1; bus.m1_raddr = 32'h0000_0300;
        @(negedge clk);
        check_eq("pre_rst_arvalid", 64'(bus.mem_arvalid), 64'd1);
        bus.m1_arvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_arvalid", 64'(bus.mem_arvalid), 64'd0);
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst_owner", 64'(bus.owner), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_grant = 1'b1;

        // Simultaneous requests straight after reset.
        pend_v[0] = 1'b1; pend_a[0] = 32'h0000_0100;
        pend_v[1] = 1'b1; pend_a[1] = 32'h0000_0200;
        run_txn(0, 0, 3'h0, 32'h1111_1111, 1'b0);
        run_txn(0, 0, 3'h0, 32'h2222_2222, 1'b0);

        // LSU read with stalls and an error response, then a normal icache read.
        pend_v[1] = 1'b1; pend_a[1] = 32'h0000_0400;
        run_txn(3, 2, 3'h2, 32'hCAFE_0001, 1'b1);
        pend_v[0] = 1'b1; pend_a[0] = 32'h0000_0500;
        run_txn(0, 0, 3'h0, 32'hCAFE_0002, 1'b0);

        // No requests: nothing starts.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("idle_stay_busy", 64'(bus.busy), 64'd0);
            check_eq("idle_stay_arvalid", 64'(bus.mem_arvalid), 64'd0);
        end

        // Both requesters held continuously.
        for (int i = 0; i < 4; i++) begin
            if (!pend_v[0]) begin pend_v[0] = 1'b1; pend_a[0] = $urandom; end
            if (!pend_v[1]) begin pend_v[1] = 1'b1; pend_a[1] = $urandom; end
            run_txn(0, 0, 3'h0, $urandom, 1'b0);
        end

        // Random traffic, including requesters that back off before being granted.
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend_v[r] && $urandom_range(0, 1) == 1) begin
                    pend_v[r] = 1'b1; pend_a[r] = $urandom;
                end
            end
            if (!pend_v[0] && !pend_v[1]) begin
                pend_v[t % 2] = 1'b1; pend_a[t % 2] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.m0_arvalid = 1'b0;
                bus.m1_arvalid = 1'b0;
                @(negedge clk);
                check_eq("backoff_busy", 64'(bus.busy), 64'd0);
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 2), 3'($urandom_range(0, 7)),
                    $urandom, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
